// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA sequencer: state encoding, operand select codes
// and the operand word-count derivation.
package rsa_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_FETCH = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   localparam logic [1:0] OP_M    = 2'd0;
   localparam logic [1:0] OP_E    = 2'd1;
   localparam logic [1:0] OP_NMOD = 2'd2;

   localparam int CNT_W = 7;
   localparam int IDX_W = 6;

   // 32-bit words per operand
   function automatic int calc_words(input int k, input int n);
      return (k * n) / 32;
   endfunction

endpackage

// File: rtl/rsa_seq_timeout.sv
// Run-phase watchdog: counts while enabled, cleared while not, flags all-ones.
module rsa_seq_timeout #(
   parameter int TMO_W = 16
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   logic [TMO_W-1:0] cnt_q;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)  cnt_q <= '0;
      else if (clr_i) cnt_q <= '0;
      else if (en_i)  cnt_q <= cnt_q + 1'b1;
   end

   assign expire_o = &cnt_q;

endmodule

// File: rtl/rsa_seq_ctrl.sv
// RSA job sequencer: streams M/E/Nmod from the forward FIFO into the core,
// starts it, then drains the result into the backward FIFO.
module rsa_seq_ctrl
   import rsa_pkg::*;
#(
   parameter int K     = 128,
   parameter int N     = 16,
   parameter int TMO_W = 16
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             start,
   input  logic             frd_vld,
   output logic             frd_rdy,
   input  logic [31:0]      frd_dat,
   output logic             op_we,
   output logic [1:0]       op_sel,
   output logic [IDX_W-1:0] op_idx,
   output logic [31:0]      op_dat,
   output logic             core_start,
   input  logic             core_done,
   output logic             res_re,
   output logic [IDX_W-1:0] res_idx,
   input  logic [31:0]      res_dat,
   output logic             bwr_vld,
   input  logic             bwr_rdy,
   output logic [31:0]      bwr_dat,
   output logic             finish,
   output logic             busy,
   output logic             err
);

   localparam int               W    = calc_words(K, N);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       sel_q, sel_d;
   logic             start_q;
   logic             cs_q, cs_d;
   logic             fin_q, fin_d;
   logic             err_q, err_d;
   logic             cap_q, cap_d;
   logic [31:0]      dat_q, dat_d;
   logic             start_rise, acc, tmo_exp;

   assign start_rise = start & ~start_q;
   assign acc        = (state_q == S_LOAD) & frd_vld;

   rsa_seq_timeout #(.TMO_W(TMO_W)) u_tmo (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .clr_i    (state_q != S_RUN),
      .en_i     (state_q == S_RUN),
      .expire_o (tmo_exp)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      cs_d    = 1'b0;
      fin_d   = fin_q;
      err_d   = err_q;
      cap_d   = 1'b0;
      dat_d   = dat_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_rise) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               sel_d   = OP_M;
               fin_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         S_LOAD: begin
            if (acc) begin
               if (cnt_q == LAST) begin
                  cnt_d = '0;
                  if (sel_q == OP_NMOD) begin
                     sel_d   = OP_M;
                     cs_d    = 1'b1;
                     state_d = S_RUN;
                  end else begin
                     sel_d = sel_q + 2'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_RUN: begin
            // core_done wins over a coincident expiry
            if (core_done) begin
               state_d = S_FETCH;
            end else if (tmo_exp) begin
               err_d   = 1'b1;
               fin_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_FETCH: begin
            cap_d   = 1'b1;
            state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (cap_q) dat_d = res_dat;
            if (bwr_rdy) begin
               if (cnt_q == LAST) begin
                  fin_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sel_q   <= OP_M;
         start_q <= 1'b0;
         cs_q    <= 1'b0;
         fin_q   <= 1'b0;
         err_q   <= 1'b0;
         cap_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         start_q <= start;
         cs_q    <= cs_d;
         fin_q   <= fin_d;
         err_q   <= err_d;
         cap_q   <= cap_d;
         dat_q   <= dat_d;
      end
   end

   assign frd_rdy    = (state_q == S_LOAD);
   assign op_we      = acc;
   assign op_sel     = frd_rdy ? sel_q : 2'd0;
   assign op_idx     = frd_rdy ? cnt_q[IDX_W-1:0] : '0;
   assign op_dat     = acc ? frd_dat : 32'd0;
   assign core_start = cs_q;
   assign res_re     = (state_q == S_FETCH);
   assign res_idx    = res_re ? cnt_q[IDX_W-1:0] : '0;
   assign bwr_vld    = (state_q == S_DRAIN);
   // first DRAIN cycle forwards the read data, later cycles hold the captured copy
   assign bwr_dat    = !bwr_vld ? 32'd0 : (cap_q ? res_dat : dat_q);
   assign finish     = fin_q;
   assign err        = err_q;
   assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: doc/rsa_seq_ctrl.md
RSA_SEQ_CTRL -- requirements
Module: rsa_seq_ctrl

Interface
REQ-001 SHALL have parameter K, default 128, operand digit width in bits.
REQ-002 SHALL have parameter N, default 16, digits per operand; W = K*N/32 = 64 words per operand.
REQ-003 SHALL have parameter TMO_W, default 16, run-timeout counter width.
REQ-004 HCLK  in  1  clock; all logic rising-edge.
REQ-005 HRESETn  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  level request from AHB slave register; acted on rising edge only.
REQ-007 frd_vld  in  1 / frd_rdy  out  1 / frd_dat  in  32  forward-FIFO read port, operand words.
REQ-008 op_we  out  1 / op_sel  out  2 (0=M,1=E,2=Nmod) / op_idx  out  6 / op_dat  out  32  core operand write.
REQ-009 core_start  out  1 pulse / core_done  in  1 pulse  RSA core control.
REQ-010 res_re  out  1 / res_idx  out  6 / res_dat  in  32  core result read, data valid 1 cycle after res_re.
REQ-011 bwr_vld  out  1 / bwr_rdy  in  1 / bwr_dat  out  32  backward-FIFO write port.
REQ-012 finish  out  1 level, cleared at next accepted start / busy  out  1 / err  out  1 sticky timeout flag.

Function
REQ-013 SHALL implement states IDLE, LOAD, RUN, FETCH, DRAIN, DONE.
REQ-014 IDLE: start rising edge -> LOAD; clear finish, err, counters; busy=1 in all states except IDLE and DONE.
REQ-015 LOAD: frd_rdy=1; each cycle frd_vld&frd_rdy SHALL write op_dat=frd_dat, op_we=1 same cycle, op_idx=word count, op_sel=operand count.
REQ-016 LOAD SHALL stall without writing while frd_vld=0; order M[0..W-1], E[0..W-1], Nmod[0..W-1].
REQ-017 After 3*W accepted words, SHALL deassert frd_rdy, pulse core_start one cycle, enter RUN.
REQ-018 RUN: timeout counter increments each cycle; core_done -> FETCH; counter all-ones before core_done -> err=1, DONE without draining.
REQ-019 FETCH: assert res_re with res_idx=result count for one cycle -> DRAIN.
REQ-020 DRAIN: bwr_vld=1, bwr_dat=res_dat captured; hold both stable until bwr_rdy; on handshake increment count and go FETCH, or DONE after W words.
REQ-021 DONE: finish=1, busy=0; next start rising edge -> LOAD; start held high from prior job SHALL NOT retrigger.
REQ-022 start edges while busy SHALL be ignored; core_done outside RUN SHALL be ignored.
REQ-023 core_done coincident with timeout expiry SHALL take core_done (no err).
REQ-024 Word counters SHALL be 7 bits, wrap-free; op_idx/res_idx = low 6 bits.
REQ-025 Throughput: LOAD one word/cycle when frd_vld steady; DRAIN one word per 2 cycles minimum.

Reset
REQ-026 On HRESETn low: state=IDLE; frd_rdy, op_we, core_start, res_re, bwr_vld, finish, busy, err = 0; op_sel, op_idx, op_dat, res_idx, bwr_dat, counters = 0; start edge detector = 0.
REQ-027 Reset mid-job SHALL abandon job; no output pulses after release until new start edge.

Structure
REQ-028 Shared package rsa_pkg SHALL hold state encoding, op_sel codes, W derivation.
REQ-029 One sub-module rsa_seq_timeout (loadable TMO_W counter with expire flag) is natural; all else in one always block plus combinational outputs.

Verification
REQ-030 Normal: start 0->1, 192 words 0x1000+i back-to-back -> op_we 192 cycles, op_sel 0/1/2 per 64, one core_start; core_done, res_dat=0xA000+idx -> 64 bwr words 0xA000..0xA03F, finish=1.
REQ-031 LOAD stall: frd_vld low cycles 10-19 -> no op_we those cycles, op_idx resumes at 10, total writes 192.
REQ-032 Backpressure: bwr_rdy low 5 cycles on word 3 -> bwr_dat 0xA003 stable throughout, no loss/duplication.
REQ-033 Timeout: TMO_W=4, no core_done -> err=1 at cycle 15 of RUN, finish=1, zero bwr_vld.
REQ-034 Retrigger: start held high through DONE -> no LOAD; start 1->0->1 -> new job, finish/err cleared.
REQ-035 Reset mid-LOAD at word 50 -> all outputs 0 within reset, IDLE after release, idle until start edge.
